// File: rtl/sat_pkg.sv
// -----------------------------------------------------------------------------
// sat_pkg
// Shared types and helpers for the SAT evaluation datapath.
//   unsat_mon_state_t : epoch state of the unsat monitor (IDLE, MONITOR, DONE)
//   idx_w()           : width of a clause index, never narrower than one bit
// -----------------------------------------------------------------------------
package sat_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    DONE    = 2'd2
  } unsat_mon_state_t;

  // Width of the timestamp counter used when cycle stamping is built.
  localparam int TS_W = 32;

  // max(1, $clog2(n)): a single-clause monitor still carries a 1-bit index.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/sat_lowest_set_idx.sv
// -----------------------------------------------------------------------------
// sat_lowest_set_idx
// Combinational priority encoder: reports the index of the lowest set bit of
// vec and whether any bit is set at all. idx is 0 when no bit is set.
// Ports:
//   vec  in   N      input flags
//   idx  out  IDX_W  index of the lowest set bit
//   any  out  1      at least one bit of vec is set
// -----------------------------------------------------------------------------
module sat_lowest_set_idx
  import sat_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/unsat_monitor.sv
// -----------------------------------------------------------------------------
// unsat_monitor
// Epoch-based conflict monitor between the clause evaluator array and the
// solver control FSM. Control starts an epoch, the evaluator streams beats of
// per-clause unsat flags, and the monitor keeps a sticky unsat result, the
// lowest clause index of the first conflicting beat and a saturating count of
// conflicting beats. Control reads the result in DONE and acknowledges it.
//
// Ports:
//   clk               in   1          clock
//   reset             in   1          synchronous, active-high
//   start             in   1          begin a new epoch (IDLE only)
//   eval_valid        in   1          clause_unsat beat valid
//   clause_unsat      in   N_CLAUSES  per-clause unsat flags
//   eval_last         in   1          final beat of the epoch
//   ack               in   1          result consumed (DONE only)
//   busy              out  1          monitoring an epoch
//   done              out  1          result valid
//   is_unsat          out  1          sticky conflict flag for the epoch
//   first_clause_idx  out  IDX_W      lowest set index of first conflicting beat
//   conflict_count    out  COUNT_W    saturating count of conflicting beats
//   first_conf_cycle  out  32         MONITOR cycle of the first conflict
//
// Build option: define UNSAT_MON_TIMESTAMP_EN to build the 32-bit MONITOR
// cycle counter behind first_conf_cycle; otherwise that port is tied to 0.
// -----------------------------------------------------------------------------
module unsat_monitor
  import sat_pkg::*;
#(
  parameter  int N_CLAUSES     = 16,
  parameter  int COUNT_W       = 8,
  parameter  int STOP_ON_FIRST = 0,
  localparam int IDX_W         = idx_w(N_CLAUSES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 eval_valid,
  input  logic [N_CLAUSES-1:0] clause_unsat,
  input  logic                 eval_last,
  input  logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic                 is_unsat,
  output logic [IDX_W-1:0]     first_clause_idx,
  output logic [COUNT_W-1:0]   conflict_count,
  output logic [TS_W-1:0]      first_conf_cycle
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic               STOP_EN   = (STOP_ON_FIRST != 0);

  unsat_mon_state_t   state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               is_unsat_q, is_unsat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               hit_s;
  logic [IDX_W-1:0]   enc_idx_s;
  logic               beat_hit_s;

`ifdef UNSAT_MON_TIMESTAMP_EN
  logic [TS_W-1:0]    cycle_q, cycle_d;
  logic [TS_W-1:0]    first_cyc_q, first_cyc_d;
`endif

  sat_lowest_set_idx #(
    .N     (N_CLAUSES),
    .IDX_W (IDX_W)
  ) u_lowest (
    .vec (clause_unsat),
    .idx (enc_idx_s),
    .any (hit_s)
  );

  assign beat_hit_s = eval_valid & hit_s;

  // Next-state and result update for the epoch FSM.
  always_comb begin
    state_d    = state_q;
    is_unsat_d = is_unsat_q;
    idx_d      = idx_q;
    count_d    = count_q;
`ifdef UNSAT_MON_TIMESTAMP_EN
    cycle_d     = cycle_q;
    first_cyc_d = first_cyc_q;
`endif

    case (state_q)
      IDLE: begin
        // Beats arriving with start are dropped: recording begins in MONITOR.
        if (start) begin
          state_d    = MONITOR;
          is_unsat_d = 1'b0;
          idx_d      = '0;
          count_d    = '0;
`ifdef UNSAT_MON_TIMESTAMP_EN
          cycle_d     = '0;
          first_cyc_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      MONITOR: begin
`ifdef UNSAT_MON_TIMESTAMP_EN
        cycle_d = cycle_q + 32'd1;
`endif
        if (beat_hit_s) begin
          is_unsat_d = 1'b1;
          count_d    = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
          // Only the first conflicting beat of the epoch is located.
          if (!is_unsat_q) begin
            idx_d = enc_idx_s;
`ifdef UNSAT_MON_TIMESTAMP_EN
            first_cyc_d = cycle_q;
`endif
          end else begin
            idx_d = idx_q;
          end
        end else begin
          count_d = count_q;
        end

        if (eval_valid && (eval_last || (hit_s && STOP_EN))) begin
          state_d = DONE;
        end else begin
          state_d = MONITOR;
        end
      end

      DONE: begin
        // start alongside ack is not taken; it must be re-issued in IDLE.
        if (ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MONITOR);
    done_d = (state_d == DONE);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_unsat_q <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      is_unsat_q <= is_unsat_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
    end
  end

`ifdef UNSAT_MON_TIMESTAMP_EN
  // MONITOR cycle counter and first-conflict timestamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q     <= '0;
      first_cyc_q <= '0;
    end else begin
      cycle_q     <= cycle_d;
      first_cyc_q <= first_cyc_d;
    end
  end

  assign first_conf_cycle = first_cyc_q;
`else
  assign first_conf_cycle = 32'd0;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign is_unsat         = is_unsat_q;
  assign first_clause_idx = idx_q;
  assign conflict_count   = count_q;

endmodule

// File: tb/tb_unsat_monitor.sv
module tb_unsat_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        eval_valid = 1'b0;
  logic        eval_last = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] clause_unsat = 16'd0;

  logic        busy0, done0, unsat0, busy1, done1, unsat1, busy2, done2, unsat2;
  logic [3:0]  idx0, idx1, idx2;
  logic [7:0]  cnt0, cnt2;
  logic [1:0]  cnt1;
  logic [31:0] cyc0, cyc1, cyc2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UNSAT_MON_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  // u0: defaults; u1: 2-bit saturating counter; u2: stop on first conflict.
  unsat_monitor #(.N_CLAUSES(16), .COUNT_W(8), .STOP_ON_FIRST(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .eval_valid(eval_valid),
    .clause_unsat(clause_unsat), .eval_last(eval_last), .ack(ack),
    .busy(busy0), .done(done0), .is_unsat(unsat0), .first_clause_idx(idx0),
    .conflict_count(cnt0), .first_conf_cycle(cyc0));

  unsat_monitor #(.N_CLAUSES(16), .COUNT_W(2), .STOP_ON_FIRST(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .eval_valid(eval_valid),
    .clause_unsat(clause_unsat), .eval_last(eval_last), .ack(ack),
    .busy(busy1), .done(done1), .is_unsat(unsat1), .first_clause_idx(idx1),
    .conflict_count(cnt1), .first_conf_cycle(cyc1));

  unsat_monitor #(.N_CLAUSES(16), .COUNT_W(8), .STOP_ON_FIRST(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .eval_valid(eval_valid),
    .clause_unsat(clause_unsat), .eval_last(eval_last), .ack(ack),
    .busy(busy2), .done(done2), .is_unsat(unsat2), .first_clause_idx(idx2),
    .conflict_count(cnt2), .first_conf_cycle(cyc2));

  // Reference model: phase 0 = waiting, 1 = epoch running, 2 = result held.
  int          ph[3];
  bit          mu[3];
  int          mi[3];
  int          mc[3];
  longint      mcyc[3];
  logic [31:0] mfc[3];
  int          cmax[3]  = '{255, 3, 255};
  bit          stopf[3] = '{1'b0, 1'b0, 1'b1};

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hit;
    for (int k = 0; k < 3; k++) begin
      hit = eval_valid && (clause_unsat != 16'd0);
      if (reset) begin
        ph[k] = 0; mu[k] = 1'b0; mi[k] = 0; mc[k] = 0; mcyc[k] = 0; mfc[k] = 32'd0;
      end else if (ph[k] == 0) begin
        if (start) begin
          ph[k] = 1; mu[k] = 1'b0; mi[k] = 0; mc[k] = 0; mcyc[k] = 0; mfc[k] = 32'd0;
        end
      end else if (ph[k] == 1) begin
        if (hit) begin
          if (!mu[k]) begin
            mi[k]  = lowest(clause_unsat);
            mfc[k] = 32'(mcyc[k]);
          end
          mu[k] = 1'b1;
          if (mc[k] < cmax[k]) mc[k] = mc[k] + 1;
        end
        mcyc[k] = (mcyc[k] + 1) % 64'h1_0000_0000;
        if (eval_valid && (eval_last || (hit && stopf[k]))) ph[k] = 2;
      end else begin
        if (ack) ph[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] ab, ad, au, ai, ac, ay;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin ab = 32'(busy0); ad = 32'(done0); au = 32'(unsat0); ai = 32'(idx0); ac = 32'(cnt0); ay = cyc0; end
        1: begin ab = 32'(busy1); ad = 32'(done1); au = 32'(unsat1); ai = 32'(idx1); ac = 32'(cnt1); ay = cyc1; end
        default: begin ab = 32'(busy2); ad = 32'(done2); au = 32'(unsat2); ai = 32'(idx2); ac = 32'(cnt2); ay = cyc2; end
      endcase
      chk($sformatf("u%0d.busy", k), ab, 32'(ph[k] == 1));
      chk($sformatf("u%0d.done", k), ad, 32'(ph[k] == 2));
      chk($sformatf("u%0d.is_unsat", k), au, 32'(mu[k]));
      chk($sformatf("u%0d.idx", k), ai, 32'(mi[k]));
      chk($sformatf("u%0d.count", k), ac, 32'(mc[k]));
      chk($sformatf("u%0d.cycle", k), ay, TS_ON ? mfc[k] : 32'd0);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v,
                      input logic [15:0] cu, input logic l, input logic a);
    reset = r; start = s; eval_valid = v; clause_unsat = cu; eval_last = l; ack = a;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic r, s, v;
    logic [15:0] cu;
    logic l, a;
    logic eb, ed, eu;
    logic [3:0] ei;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[23];

  initial begin
    //          r     s     v     cu        l     a   | busy  done  unsat idx   count
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0120, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'd2};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'd2};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 8'd2};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 8'd1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 8'd1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 8'd1};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};

    // Directed table against hand-derived constants for the default instance.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].cu, tbl[i].l, tbl[i].a);
      chk($sformatf("tbl%0d.busy", i), 32'(busy0), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d.done", i), 32'(done0), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d.is_unsat", i), 32'(unsat0), 32'(tbl[i].eu));
      chk($sformatf("tbl%0d.idx", i), 32'(idx0), 32'(tbl[i].ei));
      chk($sformatf("tbl%0d.count", i), 32'(cnt0), 32'(tbl[i].ec));
      if (i == 9) chk("tbl9.first_conf_cycle", cyc0, TS_ON ? 32'd1 : 32'd0);
    end

    // Saturation (u1) and stop-on-first (u2) sequence.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    chk("stop.done", 32'(done2), 32'd1);
    chk("stop.idx", 32'(idx2), 32'd4);
    chk("stop.count", 32'(cnt2), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    chk("sat.count", 32'(cnt1), 32'd3);
    chk("sat.idx", 32'(idx1), 32'd4);
    chk("sat.done", 32'(done1), 32'd1);
    chk("stop.count_held", 32'(cnt2), 32'd1);
    chk("wide.count", 32'(cnt0), 32'd5);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Randomized traffic checked against the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] cu;
      cu = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 2) == 0) cu = 16'h0000;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 0, cu,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
